pcileech_ft601_emu: RTL and testbench
=====================================

Name: pcileech_ft601_emu

Overview:
Synthesizable chip-side model of the FT601 245-synchronous FIFO bus. It is the other end of the pads driven by the FPGA's FT601 master (data, be, wr_n, rd_n, oe_n, siwu_n). It sources host-to-FPGA words on rxf_n/oe_n/rd_n and sinks FPGA-to-host words on txe_n/wr_n. Used for on-board loopback builds and simulation benches in place of a physical FT601; the host side is two valid/ready streams.

Parameters:
PARAM_DEPTH_LOG2, 4, log2 depth of each direction's FIFO (default 16 words).
PARAM_TXE_HOLDOFF, 0, cycles txe_n is forced high after each txe_n low-to-high transition (0 = no holdoff).

Ports:
clk  in  1  single clock for bus and host side.
rst_n  in  1  asynchronous reset, active low.
ft601_data_i  in  32  data from FPGA master (write path).
ft601_data_o  out  32  data to FPGA master (read path).
ft601_data_oe  out  1  tri-state enable for ft601_data_o; the pad wrapper resolves the inout.
ft601_be  in  4  byte enables from master, stored with each write.
ft601_wr_n  in  1  master write strobe.
ft601_rd_n  in  1  master read strobe.
ft601_oe_n  in  1  master output-enable request.
ft601_siwu_n  in  1  ignored.
ft601_rxf_n  out  1  low = data available for master.
ft601_txe_n  out  1  low = space available for master writes.
in_data  in  32  host word to send to master.
in_valid  in  1  in_data valid.
in_ready  out  1  read-path FIFO not full.
out_data  out  36  {be[3:0], data[31:0]} written by master.
out_valid  out  1  write-path FIFO not empty.
out_ready  in  1  host accepts out_data.
stat_rd_words  out  16  words popped by master (optional feature).
stat_wr_words  out  16  words pushed by master (optional feature).
err_contention  out  1  sticky protocol error (optional feature).

Behaviour:
- Reset (asynchronous, immediate): both FIFOs empty, rxf_n=1, txe_n=1, data_oe=0, in_ready=0, out_valid=0, holdoff counter=0, stats=0, err=0. in_ready=1 from the first edge after rst_n releases.
- Read path FIFO (host to master):
  - Push on edge with in_valid & in_ready.
  - Pop on edge with sampled rd_n=0 & oe_n=0 & rxf_n=0.
  - rxf_n is registered: rxf_n <= (count_next == 0). It goes low at the same edge as the first push into an empty FIFO and high at the same edge that pops the last word.
  - ft601_data_o = FIFO head (show-ahead); it advances the cycle after each pop. With an empty FIFO it holds the last value.
  - data_oe is registered: data_oe <= ~oe_n. Bus driven one cycle after oe_n falls, released one cycle after it rises.
  - rd_n=0 with oe_n=1, or with rxf_n=1: no pop.
- Write path FIFO (master to host):
  - Accept on edge with sampled wr_n=0 & txe_n=0; stores {be, data_i}.
  - txe_n is registered: txe_n <= (free_next == 0) | holdoff_active. It rises on the edge that fills the last slot, so no overflow is possible.
  - Writes while txe_n=1 are dropped silently.
  - If PARAM_TXE_HOLDOFF>0: when txe_n rises, a down-counter loads the parameter value and txe_n stays high until it reaches 0, even if space frees.
  - out side: standard valid/ready; pop on out_valid & out_ready.
- Simultaneous push and pop on either FIFO: count unchanged, flags unchanged, ordering preserved.
- Count width is PARAM_DEPTH_LOG2+1. Pointers wrap modulo depth.
- rst_n asserted mid-burst: FIFO contents discarded. Master sees rxf_n/txe_n high and the bus released in the same cycle.

Optional Feature:
Macro PCILEECH_FT601_EMU_STATS_EN.
- Defined:
  - stat_rd_words and stat_wr_words count pops and accepts, saturating at 16'hFFFF.
  - err_contention sets when sampled wr_n=0 & oe_n=0, or rd_n=0 & oe_n=1. It is sticky until reset.
- Undefined: all three outputs tied to 0 and no counter logic is generated.

Test Plan:
- Reset: rst_n=0 -> rxf_n=1, txe_n=1, data_oe=0, out_valid=0. After release -> in_ready=1 next edge, txe_n=0 next edge.
- Read burst: push 32'h11111111, 32'h22222222, 32'h33333333 -> rxf_n=0 after first push. oe_n=0 for 1 cycle, then rd_n=0 for 3 cycles -> master samples 1111…, 2222…, 3333… in order; rxf_n=1 at the edge of the third pop.
- Write fill (depth 16, out_ready=0): master writes 20 words 0..19, be=4'hF -> txe_n=1 at the edge accepting word 15, words 16..19 dropped. Drain -> out_data = {4'hF, 0}..{4'hF, 15}, then out_valid=0.
- Simultaneous events: count=1, in push and rd pop on the same edge -> rxf_n stays 0, head=new word. Same check on the write path with out_ready=1 and a write on the same edge.
- Holdoff: PARAM_TXE_HOLDOFF=4, fill then pop one word -> txe_n stays 1 for 4 cycles after its rise before returning 0.
- Stats (macro defined): after the bursts above -> stat_rd_words=3, stat_wr_words=16. Drive wr_n=0 with oe_n=0 -> err_contention=1 and stays 1 until rst_n=0.

Source files
------------

// File: rtl/pcileech_ft601_emu.sv
// FT601 245-synchronous FIFO chip model: read FIFO (host->master) and write FIFO (master->host).
// Optional statistics/contention monitor enabled by PCILEECH_FT601_EMU_STATS_EN.
module pcileech_ft601_emu #(
  parameter int PARAM_DEPTH_LOG2  = 4,
  parameter int PARAM_TXE_HOLDOFF = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ft601_data_i,
  output logic [31:0] ft601_data_o,
  output logic        ft601_data_oe,
  input  logic [3:0]  ft601_be,
  input  logic        ft601_wr_n,
  input  logic        ft601_rd_n,
  input  logic        ft601_oe_n,
  input  logic        ft601_siwu_n,
  output logic        ft601_rxf_n,
  output logic        ft601_txe_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [35:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] stat_rd_words,
  output logic [15:0] stat_wr_words,
  output logic        err_contention
);
  localparam int DEPTH = 1 << PARAM_DEPTH_LOG2;
  localparam int CW    = PARAM_DEPTH_LOG2 + 1;
  localparam int AW    = PARAM_DEPTH_LOG2;
  localparam int HW    = (PARAM_TXE_HOLDOFF > 0) ? $clog2(PARAM_TXE_HOLDOFF + 1) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt, input logic push, input logic pop);
    logic [CW-1:0] res;
    case ({push, pop})
      2'b10:   res = cnt + CW'(1);
      2'b01:   res = cnt - CW'(1);
      default: res = cnt;
    endcase
    return res;
  endfunction

  logic [31:0]   rd_mem_r [DEPTH];
  logic [AW-1:0] rd_wptr_r, rd_rptr_r, rd_rptr_next_s;
  logic [CW-1:0] rd_cnt_r, rd_cnt_next_s;
  logic [31:0]   rd_head_next_s, data_o_r;
  logic          rd_push_s, rd_pop_s, rxf_n_r, in_ready_r, data_oe_r;

  logic [35:0]   wr_mem_r [DEPTH];
  logic [AW-1:0] wr_wptr_r, wr_rptr_r, wr_rptr_next_s;
  logic [CW-1:0] wr_cnt_r, wr_cnt_next_s;
  logic [35:0]   wr_head_next_s, out_data_r;
  logic          wr_push_s, wr_pop_s, txe_n_r, txe_n_next_s, out_valid_r;
  logic [HW-1:0] hold_cnt_r;
  logic          unused_siwu_s;

  assign unused_siwu_s = ft601_siwu_n;

  assign rd_push_s      = in_valid & in_ready_r;
  assign rd_pop_s       = ~ft601_rd_n & ~ft601_oe_n & ~rxf_n_r;
  assign rd_cnt_next_s  = cnt_next(rd_cnt_r, rd_push_s, rd_pop_s);
  assign rd_rptr_next_s = rd_pop_s ? rd_rptr_r + AW'(1) : rd_rptr_r;
  // The new head is the word being pushed when the read pointer lands on the write slot.
  assign rd_head_next_s = (rd_push_s && (rd_rptr_next_s == rd_wptr_r)) ? in_data : rd_mem_r[rd_rptr_next_s];

  assign wr_push_s      = ~ft601_wr_n & ~txe_n_r;
  assign wr_pop_s       = out_valid_r & out_ready;
  assign wr_cnt_next_s  = cnt_next(wr_cnt_r, wr_push_s, wr_pop_s);
  assign wr_rptr_next_s = wr_pop_s ? wr_rptr_r + AW'(1) : wr_rptr_r;
  assign wr_head_next_s = (wr_push_s && (wr_rptr_next_s == wr_wptr_r)) ? {ft601_be, ft601_data_i} : wr_mem_r[wr_rptr_next_s];
  assign txe_n_next_s   = (wr_cnt_next_s == FULL_CNT) | (hold_cnt_r != HW'(0));

  // FIFO storage arrays (contents are don't-care once the pointers are reset)
  always_ff @(posedge clk) begin
    if (rd_push_s) rd_mem_r[rd_wptr_r] <= in_data;
    if (wr_push_s) wr_mem_r[wr_wptr_r] <= {ft601_be, ft601_data_i};
  end

  // Read-path pointers, flags and show-ahead head register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_wptr_r  <= '0;
      rd_rptr_r  <= '0;
      rd_cnt_r   <= '0;
      rxf_n_r    <= 1'b1;
      in_ready_r <= 1'b0;
      data_oe_r  <= 1'b0;
      data_o_r   <= 32'h0;
    end else begin
      if (rd_push_s) rd_wptr_r <= rd_wptr_r + AW'(1);
      rd_rptr_r  <= rd_rptr_next_s;
      rd_cnt_r   <= rd_cnt_next_s;
      rxf_n_r    <= (rd_cnt_next_s == CW'(0));
      in_ready_r <= (rd_cnt_next_s != FULL_CNT);
      data_oe_r  <= ~ft601_oe_n;
      if (rd_cnt_next_s != CW'(0)) data_o_r <= rd_head_next_s;
    end
  end

  // Write-path pointers, txe_n with holdoff, and host-side head register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_wptr_r   <= '0;
      wr_rptr_r   <= '0;
      wr_cnt_r    <= '0;
      txe_n_r     <= 1'b1;
      hold_cnt_r  <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= 36'h0;
    end else begin
      if (wr_push_s) wr_wptr_r <= wr_wptr_r + AW'(1);
      wr_rptr_r   <= wr_rptr_next_s;
      wr_cnt_r    <= wr_cnt_next_s;
      txe_n_r     <= txe_n_next_s;
      out_valid_r <= (wr_cnt_next_s != CW'(0));
      if (wr_cnt_next_s != CW'(0)) out_data_r <= wr_head_next_s;
      if (txe_n_next_s && !txe_n_r) hold_cnt_r <= HW'(PARAM_TXE_HOLDOFF);
      else if (hold_cnt_r != HW'(0)) hold_cnt_r <= hold_cnt_r - HW'(1);
    end
  end

  assign ft601_data_o  = data_o_r;
  assign ft601_data_oe = data_oe_r;
  assign ft601_rxf_n   = rxf_n_r;
  assign ft601_txe_n   = txe_n_r;
  assign in_ready      = in_ready_r;
  assign out_data      = out_data_r;
  assign out_valid     = out_valid_r;

`ifdef PCILEECH_FT601_EMU_STATS_EN
  logic [15:0] stat_rd_r, stat_wr_r;
  logic        err_r;

  // Saturating traffic counters and sticky bus-contention flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_r <= 16'h0;
      stat_wr_r <= 16'h0;
      err_r     <= 1'b0;
    end else begin
      if (rd_pop_s && (stat_rd_r != 16'hFFFF)) stat_rd_r <= stat_rd_r + 16'd1;
      if (wr_push_s && (stat_wr_r != 16'hFFFF)) stat_wr_r <= stat_wr_r + 16'd1;
      if ((~ft601_wr_n & ~ft601_oe_n) | (~ft601_rd_n & ft601_oe_n)) err_r <= 1'b1;
    end
  end

  assign stat_rd_words  = stat_rd_r;
  assign stat_wr_words  = stat_wr_r;
  assign err_contention = err_r;
`else
  assign stat_rd_words  = 16'h0;
  assign stat_wr_words  = 16'h0;
  assign err_contention = 1'b0;
`endif

endmodule

// File: tb/tb_pcileech_ft601_emu.sv
// Directed bench for pcileech_ft601_emu (depth 16, txe holdoff 4); stats checks follow PCILEECH_FT601_EMU_STATS_EN.
module tb_pcileech_ft601_emu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ft601_data_i, ft601_data_o, in_data;
  logic        ft601_data_oe, ft601_wr_n, ft601_rd_n, ft601_oe_n, ft601_siwu_n;
  logic [3:0]  ft601_be;
  logic        ft601_rxf_n, ft601_txe_n, in_valid, in_ready, out_valid, out_ready;
  logic [35:0] out_data;
  logic [15:0] stat_rd_words, stat_wr_words;
  logic        err_contention;

  int n_vec  = 0;
  int n_fail = 0;

`ifdef PCILEECH_FT601_EMU_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  pcileech_ft601_emu #(.PARAM_DEPTH_LOG2(4), .PARAM_TXE_HOLDOFF(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ft601_data_i(ft601_data_i), .ft601_data_o(ft601_data_o), .ft601_data_oe(ft601_data_oe),
    .ft601_be(ft601_be), .ft601_wr_n(ft601_wr_n), .ft601_rd_n(ft601_rd_n), .ft601_oe_n(ft601_oe_n),
    .ft601_siwu_n(ft601_siwu_n), .ft601_rxf_n(ft601_rxf_n), .ft601_txe_n(ft601_txe_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .stat_rd_words(stat_rd_words), .stat_wr_words(stat_wr_words), .err_contention(err_contention)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] in_data;
    logic        in_valid;
    logic        rd_n;
    logic        oe_n;
    logic        exp_rxf_n;
    logic        exp_oe;
    logic [31:0] exp_dout;
  } rd_vec_t;

  rd_vec_t tbl [13];

  initial begin
    tbl[0]  = '{32'h11111111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11111111};
    tbl[1]  = '{32'h22222222, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11111111};
    tbl[2]  = '{32'h33333333, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11111111};
    tbl[3]  = '{32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h11111111};
    tbl[4]  = '{32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h22222222};
    tbl[5]  = '{32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h33333333};
    tbl[6]  = '{32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33333333};
    tbl[7]  = '{32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h33333333};
    tbl[8]  = '{32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33333333};
    tbl[9]  = '{32'hAAAAAAAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAAAAAA};
    tbl[10] = '{32'hBBBBBBBB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBBBBBBBB};
    tbl[11] = '{32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hBBBBBBBB};
    tbl[12] = '{32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hBBBBBBBB};

    rst_n = 1'b0; ft601_data_i = 32'h0; ft601_be = 4'h0; ft601_wr_n = 1'b1; ft601_rd_n = 1'b1;
    ft601_oe_n = 1'b1; ft601_siwu_n = 1'b1; in_data = 32'h0; in_valid = 1'b0; out_ready = 1'b0;

    // Reset state and release
    step();
    chk("rst_rxf_n", 64'(ft601_rxf_n), 64'd1);
    chk("rst_txe_n", 64'(ft601_txe_n), 64'd1);
    chk("rst_data_oe", 64'(ft601_data_oe), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_txe_n", 64'(ft601_txe_n), 64'd0);
    chk("rel_rxf_n", 64'(ft601_rxf_n), 64'd1);

    // Read path: burst, empty-read, simultaneous push/pop
    for (int i = 0; i < 13; i++) begin
      in_data = tbl[i].in_data; in_valid = tbl[i].in_valid;
      ft601_rd_n = tbl[i].rd_n; ft601_oe_n = tbl[i].oe_n;
      step();
      chk($sformatf("rd_v%0d_rxf_n", i), 64'(ft601_rxf_n), 64'(tbl[i].exp_rxf_n));
      chk($sformatf("rd_v%0d_data_oe", i), 64'(ft601_data_oe), 64'(tbl[i].exp_oe));
      chk($sformatf("rd_v%0d_data_o", i), 64'(ft601_data_o), 64'(tbl[i].exp_dout));
    end
    in_valid = 1'b0;

    // Write fill past capacity with host stalled
    for (int i = 0; i < 20; i++) begin
      ft601_wr_n = 1'b0; ft601_data_i = 32'(i); ft601_be = 4'hF;
      step();
      chk($sformatf("fill_txe_n_%0d", i), 64'(ft601_txe_n), (i >= 15) ? 64'd1 : 64'd0);
    end
    ft601_wr_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_valid_%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("drain_data_%0d", i), 64'(out_data), {28'h0, 4'hF, 32'(i)});
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("drain_txe_n", 64'(ft601_txe_n), 64'd0);

    // Holdoff: fill, pop one word, txe_n must stay high 4 more cycles
    for (int i = 0; i < 16; i++) begin
      ft601_wr_n = 1'b0; ft601_data_i = 32'(100 + i); ft601_be = 4'hA;
      step();
    end
    ft601_wr_n = 1'b1;
    chk("hold_full_txe_n", 64'(ft601_txe_n), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("hold_txe_n_%0d", k), 64'(ft601_txe_n), 64'd1);
      step();
    end
    chk("hold_release_txe_n", 64'(ft601_txe_n), 64'd0);

    // Drain to one word, then pop and write on the same edge
    out_ready = 1'b1;
    for (int i = 1; i < 15; i++) begin
      chk($sformatf("hdrain_data_%0d", i), 64'(out_data), {28'h0, 4'hA, 32'(100 + i)});
      step();
    end
    chk("sim_wr_head", 64'(out_data), {28'h0, 4'hA, 32'd115});
    ft601_wr_n = 1'b0; ft601_data_i = 32'h0000CAFE; ft601_be = 4'h3;
    step();
    ft601_wr_n = 1'b1;
    chk("sim_wr_valid", 64'(out_valid), 64'd1);
    chk("sim_wr_data", 64'(out_data), {28'h0, 4'h3, 32'h0000CAFE});
    chk("sim_wr_txe_n", 64'(ft601_txe_n), 64'd0);
    step();
    out_ready = 1'b0;
    chk("sim_wr_empty", 64'(out_valid), 64'd0);

    // Statistics and sticky contention flag
    chk("stat_rd", 64'(stat_rd_words), STATS ? 64'd5 : 64'd0);
    chk("stat_wr", 64'(stat_wr_words), STATS ? 64'd33 : 64'd0);
    chk("err_clean", 64'(err_contention), 64'd0);
    ft601_wr_n = 1'b0; ft601_oe_n = 1'b0; ft601_data_i = 32'h5;
    step();
    ft601_wr_n = 1'b1; ft601_oe_n = 1'b1;
    chk("err_set", 64'(err_contention), STATS ? 64'd1 : 64'd0);
    step(); step();
    chk("err_sticky", 64'(err_contention), STATS ? 64'd1 : 64'd0);

    // Asynchronous reset mid-burst
    in_valid = 1'b1; in_data = 32'h77777777; ft601_oe_n = 1'b0;
    step();
    in_valid = 1'b0;
    chk("pre_rst_rxf_n", 64'(ft601_rxf_n), 64'd0);
    chk("pre_rst_oe", 64'(ft601_data_oe), 64'd1);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rxf_n", 64'(ft601_rxf_n), 64'd1);
    chk("mid_rst_txe_n", 64'(ft601_txe_n), 64'd1);
    chk("mid_rst_oe", 64'(ft601_data_oe), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_err", 64'(err_contention), 64'd0);
    chk("mid_rst_stat", 64'({stat_rd_words, stat_wr_words}), 64'd0);
    ft601_oe_n = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("post_rst_rxf_n", 64'(ft601_rxf_n), 64'd1);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
